perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of NUM_COUNTERS event counters, replacing the fixed two-counter perf logic.
//  Each counter selects one of NUM_EVENTS single-cycle event strobes and counts it.
//  Counters are COUNTER_WIDTH bits wide and accessed through 32-bit control-register reads/writes.
//  Sits beside the core's control registers, fed by core_perf_events / l2_perf_events.
// PARAMETERS
//  NUM_EVENTS     14  number of event inputs (CORE_PERF_EVENTS)
//  NUM_COUNTERS   4   number of counters, power of 2, 1..16
//  COUNTER_WIDTH  48  counter width, 33..64
// PORTS
//  clk            in   1                   core clock
//  reset_n        in   1                   asynchronous reset, active low
//  perf_events    in   NUM_EVENTS          event strobes, one count per high cycle
//  cr_write_en    in   1                   register write strobe
//  cr_read_en     in   1                   register read strobe; mutually exclusive with cr_write_en
//  cr_addr        in   $clog2(NUM_COUNTERS)+2  {counter index, sub-register[1:0]}
//  cr_write_data  in   32                  write data
//  cr_read_data   out  32                  read data, valid 1 cycle after cr_read_en
//  overflow_irq   out  1                   level interrupt, OR of enabled sticky overflows
// BEHAVIOUR
//  Sub-registers (per counter):
//   0 SELECT = event index (low $clog2(NUM_EVENTS) bits).
//   1 COUNT_L = count[31:0].
//   2 COUNT_H = count[W-1:32], zero-extended.
//   3 CTRL: bit0 enable; bit1 ovf sticky (W1C); bit2 ovf irq enable.
//  Reset: all counts 0, SELECT 0, CTRL 0, shadow 0, cr_read_data 0, overflow_irq 0.
//  Count rule: +1 on the cycle after perf_events[SELECT] is high, if enable=1.
//   SELECT >= NUM_EVENTS: the counter holds (no count).
//  Wrap: at 2^W-1 the next increment yields 0 and sets ovf sticky in the same edge.
//  Write COUNT_L/COUNT_H replaces only that half.
//   An increment in the same cycle is dropped; the write wins.
//   A carry from the low half is never applied after a COUNT_H write.
//  Coherent 64-bit read:
//   A COUNT_L read snapshots count[W-1:32] into a per-counter shadow on that edge.
//   A COUNT_H read returns the shadow, not the live value.
//   Software reads L then H.
//  Read latency is 1 cycle. cr_read_data holds its value until the next cr_read_en.
//   Reads of unused bits return 0.
//  A read coinciding with an increment returns the pre-increment value.
//  Writes to reserved CTRL bits are ignored.
//   CTRL bit1 write of 1 clears the sticky bit; writing 0 leaves it unchanged.
//   If a new overflow and a clear land in the same cycle, set wins.
//  Enable 1->0 freezes the count immediately. Re-enabling resumes without loss of value.
//  reset_n assertion mid-operation clears all state asynchronously.
//   The first count occurs no earlier than the first clk edge after deassertion.
// CONFIGURATION
//  PERF_OVERFLOW_IRQ_EN defined:
//   CTRL bits1-2 are live.
//   overflow_irq = |(sticky & irq_en) across counters, registered (1 cycle after the overflow edge).
//  Undefined:
//   Overflow sticky logic is not built. CTRL bits1-2 read 0 and writes are ignored.
//   overflow_irq is tied 0. Counters still wrap silently.
// TESTING
//  1. Reset -> every sub-register reads 0 and overflow_irq=0.
//  2. SELECT0=3, CTRL0=1, pulse perf_events[3] for 10 cycles
//     -> COUNT_L0=10, COUNT_H0=0. Counter 1 (disabled) stays 0.
//  3. Write COUNT_H0=0xFFFF and COUNT_L0=0xFFFFFFFE (W=48), enable, 3 events
//     -> COUNT_L0=1, COUNT_H0=0. With _EN: CTRL0 bit1=1.
//  4. COUNT_L0=0xFFFFFFFF, read COUNT_L, event increments to carry, read COUNT_H
//     -> returns the pre-carry shadow high value.
//  5. With _EN: CTRL2=0x5, overflow counter 2 -> overflow_irq=1 one cycle later.
//     Write CTRL2=0x7 -> irq drops next cycle.
//     Without _EN: irq stays 0.
//  6. SELECT1=NUM_EVENTS, all events high -> COUNT_L1 stays 0.
//     Then write COUNT_L1=5 during an event on a valid select -> reads 5.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of event counters with per-counter event select, 32-bit register access and
// coherent L/H reads through a shadow. The overflow sticky/IRQ logic exists only with PERF_OVERFLOW_IRQ_EN.
module perf_counter_bank #(
  parameter int NUM_EVENTS    = 14,
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_EVENTS-1:0]             perf_events,
  input  logic                              cr_write_en,
  input  logic                              cr_read_en,
  input  logic [$clog2(NUM_COUNTERS)+1:0]   cr_addr,
  input  logic [31:0]                       cr_write_data,
  output logic [31:0]                       cr_read_data,
  output logic                              overflow_irq
);

  localparam int AW     = $clog2(NUM_COUNTERS) + 2;
  localparam int IDX_W  = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam int SEL_W  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int EV_PAD = 1 << SEL_W;
  localparam int W      = COUNTER_WIDTH;
  localparam int HI_W   = W - 32;

  logic [1:0]        sub;
  logic [IDX_W-1:0]  idx;
  logic [EV_PAD-1:0] ev_pad;
  logic [31:0]       rd_word [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] irq_vec;
  logic [31:0]       rd_data_d, rd_data_q;

  assign sub = cr_addr[1:0];

  generate
    if (NUM_COUNTERS > 1) begin : g_idx
      assign idx = cr_addr[AW-1:2];
    end else begin : g_idx_single
      assign idx = '0;
    end
  endgenerate

  // Unimplemented select codes map to zero bits, so such a counter simply holds.
  assign ev_pad = EV_PAD'(perf_events);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_ctr
      logic             hit;
      logic             inc;
      logic [SEL_W-1:0] sel_d, sel_q;
      logic             en_d, en_q;
      logic [W-1:0]     count_d, count_q;
      logic [HI_W-1:0]  shadow_d, shadow_q;
      logic [31:0]      word;
`ifdef PERF_OVERFLOW_IRQ_EN
      logic             sticky_d, sticky_q;
      logic             irq_en_d, irq_en_q;
`endif

      assign hit = (idx == IDX_W'(gi));
      assign inc = en_q & ev_pad[sel_q];

      always_comb begin
        sel_d    = sel_q;
        en_d     = en_q;
        count_d  = count_q;
        shadow_d = shadow_q;
`ifdef PERF_OVERFLOW_IRQ_EN
        sticky_d = sticky_q;
        irq_en_d = irq_en_q;
`endif
        // Register writes take priority over the increment in the same cycle.
        if (cr_write_en && hit && sub == 2'd1) begin
          count_d[31:0] = cr_write_data;
        end else if (cr_write_en && hit && sub == 2'd2) begin
          count_d[W-1:32] = cr_write_data[HI_W-1:0];
        end else if (inc) begin
          count_d = count_q + W'(1);
        end
        if (cr_write_en && hit && sub == 2'd0) begin
          sel_d = cr_write_data[SEL_W-1:0];
        end
        if (cr_write_en && hit && sub == 2'd3) begin
          en_d = cr_write_data[0];
`ifdef PERF_OVERFLOW_IRQ_EN
          irq_en_d = cr_write_data[2];
          if (cr_write_data[1]) sticky_d = 1'b0;
`endif
        end
`ifdef PERF_OVERFLOW_IRQ_EN
        // A wrap in the same cycle as a clear keeps the sticky set.
        if (!(cr_write_en && hit && (sub == 2'd1 || sub == 2'd2)) && inc && (&count_q)) begin
          sticky_d = 1'b1;
        end
`endif
        if (cr_read_en && hit && sub == 2'd1) begin
          shadow_d = count_q[W-1:32];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sel_q    <= '0;
          en_q     <= 1'b0;
          count_q  <= '0;
          shadow_q <= '0;
`ifdef PERF_OVERFLOW_IRQ_EN
          sticky_q <= 1'b0;
          irq_en_q <= 1'b0;
`endif
        end else begin
          sel_q    <= sel_d;
          en_q     <= en_d;
          count_q  <= count_d;
          shadow_q <= shadow_d;
`ifdef PERF_OVERFLOW_IRQ_EN
          sticky_q <= sticky_d;
          irq_en_q <= irq_en_d;
`endif
        end
      end

      always_comb begin
        word = '0;
        case (sub)
          2'd0: word = 32'(sel_q);
          2'd1: word = count_q[31:0];
          2'd2: word = 32'(shadow_q);
`ifdef PERF_OVERFLOW_IRQ_EN
          default: word = {29'd0, irq_en_q, sticky_q, en_q};
`else
          default: word = {31'd0, en_q};
`endif
        endcase
      end

      assign rd_word[gi] = word;
`ifdef PERF_OVERFLOW_IRQ_EN
      assign irq_vec[gi] = sticky_q & irq_en_q;
`else
      assign irq_vec[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    rd_data_d = rd_data_q;
    if (cr_read_en) rd_data_d = rd_word[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign cr_read_data = rd_data_q;

`ifdef PERF_OVERFLOW_IRQ_EN
  logic irq_d, irq_q;

  assign irq_d = |irq_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign overflow_irq = irq_q;
`else
  logic unused_irq_vec;
  assign unused_irq_vec = |irq_vec;
  assign overflow_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (default parameters). Expectations follow
// PERF_OVERFLOW_IRQ_EN when the bench is compiled with that macro.
module tb_perf_counter_bank;

`ifdef PERF_OVERFLOW_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [13:0] perf_events;
  logic        cr_write_en;
  logic        cr_read_en;
  logic [3:0]  cr_addr;
  logic [31:0] cr_write_data;
  logic [31:0] cr_read_data;
  logic        overflow_irq;

  int n_cmp = 0;
  int n_bad = 0;

  perf_counter_bank #(.NUM_EVENTS(14), .NUM_COUNTERS(4), .COUNTER_WIDTH(48)) dut (
    .clk(clk), .reset_n(reset_n), .perf_events(perf_events),
    .cr_write_en(cr_write_en), .cr_read_en(cr_read_en), .cr_addr(cr_addr),
    .cr_write_data(cr_write_data), .cr_read_data(cr_read_data), .overflow_irq(overflow_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cr_write(input logic [3:0] a, input logic [31:0] d);
    cr_write_en = 1'b1; cr_addr = a; cr_write_data = d;
    @(posedge clk); #1;
    cr_write_en = 1'b0;
    $display("wr  addr=%0d data=%h", a, d);
  endtask

  task automatic cr_read(input logic [3:0] a, output logic [31:0] d);
    cr_read_en = 1'b1; cr_addr = a;
    @(posedge clk); #1;
    cr_read_en = 1'b0;
    d = cr_read_data;
    $display("rd  addr=%0d data=%h", a, d);
  endtask

  task automatic pulse(input int ev, input int n);
    perf_events = 14'(1 << ev);
    repeat (n) @(posedge clk);
    #1;
    perf_events = '0;
    $display("evt %0d x%0d", ev, n);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0; perf_events = '0; cr_write_en = 1'b0; cr_read_en = 1'b0;
    cr_addr = '0; cr_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_cmp++;
    if (overflow_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", overflow_irq); end
    for (int a = 0; a < 16; a++) begin
      cr_read(4'(a), rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 0", a, rd); end
    end
  endtask

  task automatic test_count();
    logic [31:0] rd;
    cr_write(4'd0, 32'd3);
    cr_write(4'd3, 32'd1);
    pulse(3, 10);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd10) begin n_bad++; $display("FAIL count_l0: got %h want %h", rd, 32'd10); end
    cr_read(4'd2, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL count_h0: got %h want 0", rd); end
    cr_read(4'd5, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL count_l1_disabled: got %h want 0", rd); end
    cr_read(4'd0, rd); n_cmp++;
    if (rd !== 32'd3) begin n_bad++; $display("FAIL select0: got %h want 3", rd); end
    cr_write(4'd3, 32'd0);
    pulse(3, 5);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd10) begin n_bad++; $display("FAIL frozen_l0: got %h want %h", rd, 32'd10); end
    cr_write(4'd3, 32'd1);
    pulse(3, 2);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd12) begin n_bad++; $display("FAIL resume_l0: got %h want %h", rd, 32'd12); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [31:0] ctrl_exp;
    cr_write(4'd2, 32'h0000FFFF);
    cr_write(4'd1, 32'hFFFFFFFE);
    pulse(3, 3);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL wrap_l0: got %h want 1", rd); end
    cr_read(4'd2, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL wrap_h0: got %h want 0", rd); end
    ctrl_exp = IRQ_EN ? 32'd3 : 32'd1;
    cr_read(4'd3, rd); n_cmp++;
    if (rd !== ctrl_exp) begin n_bad++; $display("FAIL wrap_ctrl0: got %h want %h", rd, ctrl_exp); end
    n_cmp++;
    if (overflow_irq !== 1'b0) begin n_bad++; $display("FAIL wrap_irq_masked: got %b want 0", overflow_irq); end
    cr_write(4'd3, 32'hFFFFFFF9);
    cr_read(4'd3, rd); n_cmp++;
    if (rd !== ctrl_exp) begin n_bad++; $display("FAIL w0_keeps_sticky: got %h want %h", rd, ctrl_exp); end
    cr_write(4'd3, 32'd3);
    cr_read(4'd3, rd); n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL w1c_sticky: got %h want 1", rd); end
  endtask

  task automatic test_shadow();
    logic [31:0] rd;
    cr_write(4'd2, 32'h12);
    cr_write(4'd1, 32'hFFFFFFFF);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL shadow_l: got %h want ffffffff", rd); end
    pulse(3, 1);
    cr_read(4'd2, rd); n_cmp++;
    if (rd !== 32'h12) begin n_bad++; $display("FAIL shadow_h_pre_carry: got %h want 12", rd); end
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL carry_l: got %h want 0", rd); end
    cr_read(4'd2, rd); n_cmp++;
    if (rd !== 32'h13) begin n_bad++; $display("FAIL carry_h: got %h want 13", rd); end
    perf_events = 14'h0008;
    cr_read(4'd1, rd);
    perf_events = '0;
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL read_pre_inc: got %h want 0", rd); end
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL read_post_inc: got %h want 1", rd); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cr_read_data !== 32'd1) begin n_bad++; $display("FAIL read_hold: got %h want 1", cr_read_data); end
    cr_write(4'd1, 32'hAB);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'hAB) begin n_bad++; $display("FAIL half_write_l: got %h want ab", rd); end
    cr_read(4'd2, rd); n_cmp++;
    if (rd !== 32'h13) begin n_bad++; $display("FAIL half_write_h: got %h want 13", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic [31:0] ctrl_exp;
    cr_write(4'd8, 32'd5);
    cr_write(4'd10, 32'h0000FFFF);
    cr_write(4'd9, 32'hFFFFFFFF);
    cr_write(4'd11, 32'h5);
    pulse(5, 1);
    n_cmp++;
    if (overflow_irq !== 1'b0) begin n_bad++; $display("FAIL irq_not_yet: got %b want 0", overflow_irq); end
    @(posedge clk); #1;
    n_cmp++;
    if (overflow_irq !== IRQ_EN) begin n_bad++; $display("FAIL irq_raised: got %b want %b", overflow_irq, IRQ_EN); end
    cr_write(4'd11, 32'h7);
    n_cmp++;
    if (overflow_irq !== IRQ_EN) begin n_bad++; $display("FAIL irq_clear_lag: got %b want %b", overflow_irq, IRQ_EN); end
    @(posedge clk); #1;
    n_cmp++;
    if (overflow_irq !== 1'b0) begin n_bad++; $display("FAIL irq_dropped: got %b want 0", overflow_irq); end
    ctrl_exp = IRQ_EN ? 32'h5 : 32'h1;
    cr_read(4'd11, rd); n_cmp++;
    if (rd !== ctrl_exp) begin n_bad++; $display("FAIL ctrl2: got %h want %h", rd, ctrl_exp); end
    cr_read(4'd9, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL wrap_l2: got %h want 0", rd); end
  endtask

  task automatic test_select_and_write();
    logic [31:0] rd;
    cr_write(4'd4, 32'd14);
    cr_write(4'd7, 32'd1);
    perf_events = '1;
    repeat (5) @(posedge clk);
    #1;
    perf_events = '0;
    cr_read(4'd5, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL bad_select_holds: got %h want 0", rd); end
    cr_write(4'd4, 32'd2);
    perf_events = 14'h0004;
    cr_write(4'd5, 32'd5);
    perf_events = '0;
    cr_read(4'd5, rd); n_cmp++;
    if (rd !== 32'd5) begin n_bad++; $display("FAIL write_beats_inc: got %h want 5", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    cr_write(4'd1, 32'd0);
    cr_write(4'd2, 32'd0);
    pulse(3, 4);
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd4) begin n_bad++; $display("FAIL pre_reset_l0: got %h want 4", rd); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (cr_read_data !== 32'd0) begin n_bad++; $display("FAIL async_rd_clear: got %h want 0", cr_read_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cr_read(4'd1, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL post_reset_l0: got %h want 0", rd); end
    cr_read(4'd3, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL post_reset_ctrl0: got %h want 0", rd); end
    cr_read(4'd5, rd); n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL post_reset_l1: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_shadow();
    test_irq();
    test_select_and_write();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
